// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-bus request/response, redirect and decode handoff signals; master = fetch unit, slave = environment
interface fetch_unit_if;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_raw_instr;
  logic [63:0] out_pc;
  logic        out_ready;
  modport master (
    output ireq_valid, ireq_addr, out_valid, out_raw_instr, out_pc,
    input  iresp_addr_ok, iresp_data_ok, iresp_data, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  ireq_valid, ireq_addr, out_valid, out_raw_instr, out_pc,
    output iresp_addr_ok, iresp_data_ok, iresp_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with redirect squash; ports clk, reset (sync, active-high), bus (fetch_unit_if.master: ireq/iresp bus, redirect, decode output)
module fetch_unit #(
  parameter logic [63:0] PCINIT = 64'h0000_0000_8000_0000
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  typedef enum logic [1:0] {FETCH, WAIT, FULL} state_t;
  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d, req_q, req_d, opc_q, opc_d;
  logic [31:0] ins_q, ins_d;
  logic        squash_q, squash_d, done, drop;
  assign bus.ireq_valid    = state_q == FETCH && !reset;
  assign bus.ireq_addr     = req_q;
  assign bus.out_valid     = state_q == FULL;
  assign bus.out_raw_instr = ins_q;
  assign bus.out_pc        = opc_q;
  assign done = bus.iresp_data_ok && (state_q == WAIT || (state_q == FETCH && bus.iresp_addr_ok));
  assign drop = done && (squash_q || bus.redirect_valid);
  always_comb begin
    state_d  = state_q;
    pc_d     = bus.redirect_valid ? bus.redirect_pc : pc_q;
    req_d    = req_q;
    opc_d    = opc_q;
    ins_d    = ins_q;
    squash_d = squash_q;
    case (state_q)
      FETCH, WAIT: begin
        if (drop) begin
          state_d  = FETCH;
          squash_d = 1'b0;
          req_d    = pc_d;
        end else if (done) begin
          state_d = FULL;
          ins_d   = bus.iresp_data;
          opc_d   = req_q;
        end else begin
          squash_d = squash_q || bus.redirect_valid;
          if (state_q == FETCH && bus.iresp_addr_ok) state_d = WAIT;
        end
      end
      FULL: begin
        if (bus.redirect_valid) begin
          state_d = FETCH;
          req_d   = bus.redirect_pc;
        end else if (bus.out_ready) begin
          state_d = FETCH;
          pc_d    = opc_q + 64'd4;
          req_d   = opc_q + 64'd4;
        end
      end
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= PCINIT;
      req_q    <= PCINIT;
      opc_q    <= '0;
      ins_q    <= '0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      opc_q    <= opc_d;
      ins_q    <= ins_d;
      squash_q <= squash_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus against a transaction-level model of the fetch unit
module tb_fetch_unit;
  localparam logic [63:0] PC = 64'h0000_0000_8000_0000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vec = 0;
  int   err = 0;
  fetch_unit_if bus ();
  fetch_unit #(.PCINIT(PC)) dut (.clk(clk), .reset(reset), .bus(bus.master));
  always #5 clk = ~clk;
  logic [63:0] m_pc, m_req, m_opc;
  logic [31:0] m_ins;
  logic        m_acc, m_doom, m_hold, arrived, exp_iv;
  assign arrived = bus.iresp_data_ok && (m_acc || bus.iresp_addr_ok);
  assign exp_iv  = !reset && !m_hold && !m_acc;
  always @(posedge clk) begin
    if (reset) begin
      m_pc   <= PC;
      m_req  <= PC;
      m_opc  <= '0;
      m_ins  <= '0;
      m_acc  <= 1'b0;
      m_doom <= 1'b0;
      m_hold <= 1'b0;
    end else if (m_hold) begin
      if (bus.redirect_valid) begin
        m_hold <= 1'b0;
        m_pc   <= bus.redirect_pc;
        m_req  <= bus.redirect_pc;
      end else if (bus.out_ready) begin
        m_hold <= 1'b0;
        m_pc   <= m_opc + 64'd4;
        m_req  <= m_opc + 64'd4;
      end
    end else begin
      if (bus.redirect_valid) m_pc <= bus.redirect_pc;
      if (arrived) begin
        m_acc <= 1'b0;
        if (m_doom || bus.redirect_valid) begin
          m_doom <= 1'b0;
          m_req  <= bus.redirect_valid ? bus.redirect_pc : m_pc;
        end else begin
          m_hold <= 1'b1;
          m_opc  <= m_req;
          m_ins  <= bus.iresp_data;
        end
      end else begin
        if (bus.iresp_addr_ok) m_acc <= 1'b1;
        if (bus.redirect_valid) m_doom <= 1'b1;
      end
    end
  end
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vec++;
    if (a !== e) begin
      err++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    #3;
    chk("ireq_valid", {63'd0, bus.ireq_valid}, {63'd0, exp_iv});
    if (exp_iv) chk("ireq_addr", bus.ireq_addr, m_req);
    chk("out_valid", {63'd0, bus.out_valid}, {63'd0, m_hold});
    chk("out_pc", bus.out_pc, m_opc);
    chk("out_raw_instr", {32'd0, bus.out_raw_instr}, {32'd0, m_ins});
  end
  task automatic cyc(input logic r, input logic a, input logic d, input logic rv, input logic rdy,
                     input logic [63:0] rpc, input logic [31:0] data);
    @(negedge clk);
    reset              = r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
    bus.iresp_data     = data;
    bus.iresp_addr_ok  = 1'b0;
    bus.iresp_data_ok  = 1'b0;
    #1;
    bus.iresp_addr_ok = a && bus.ireq_valid;
    bus.iresp_data_ok = d && (m_acc || bus.iresp_addr_ok);
    #1;
  endtask
  task automatic rst();
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rst_ireq_valid", {63'd0, bus.ireq_valid}, 0);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
  endtask
  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    bus.iresp_data     = '0;
    bus.iresp_addr_ok  = 1'b0;
    bus.iresp_data_ok  = 1'b0;
    rst();
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 1, 0, 1, 0, $urandom);
      chk("zw_out_valid", {63'd0, bus.out_valid}, 64'(i % 2));
      if (i % 2 == 0) chk("zw_addr", bus.ireq_addr, PC + 64'(2 * i));
      else chk("zw_out_pc", bus.out_pc, PC + 64'(2 * (i - 1)));
    end
    rst();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("slow_valid", {63'd0, bus.ireq_valid}, 1);
      chk("slow_addr", bus.ireq_addr, PC);
    end
    cyc(0, 1, 1, 0, 0, 0, 32'hDEAD_BEEF);
    chk("slow_addr4", bus.ireq_addr, PC);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0, 0, $urandom);
      chk("hold_valid", {63'd0, bus.out_valid}, 1);
      chk("hold_pc", bus.out_pc, PC);
      chk("hold_instr", {32'd0, bus.out_raw_instr}, 64'hDEAD_BEEF);
      chk("hold_ireq", {63'd0, bus.ireq_valid}, 0);
    end
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("release_addr", bus.ireq_addr, PC + 64'd4);
    rst();
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 64'h8000_1000, 0);
    chk("wait_ireq", {63'd0, bus.ireq_valid}, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 32'h13);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("squash_out_valid", {63'd0, bus.out_valid}, 0);
    chk("squash_addr", bus.ireq_addr, 64'h8000_1000);
    rst();
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 64'h100, 0);
    cyc(0, 0, 0, 1, 0, 64'h200, 0);
    cyc(0, 0, 1, 0, 0, 0, 32'h13);
    cyc(0, 1, 1, 0, 0, 0, 32'h55);
    chk("last_wins_out", {63'd0, bus.out_valid}, 0);
    chk("last_wins_addr", bus.ireq_addr, 64'h200);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("last_wins_pc", bus.out_pc, 64'h200);
    chk("last_wins_instr", {32'd0, bus.out_raw_instr}, 64'h55);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("midwait_rst_ireq", {63'd0, bus.ireq_valid}, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_valid", {63'd0, bus.ireq_valid}, 1);
    chk("post_rst_addr", bus.ireq_addr, PC);
    cyc(0, 1, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h66);
    cyc(0, 1, 1, 0, 0, 0, 32'h77);
    chk("wrap_req", bus.ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("wrap_pc", bus.out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("wrap_next", bus.ireq_addr, 64'h0);
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] t;
      t = {$urandom, $urandom};
      t[1:0] = 2'b00;
      cyc($urandom_range(99) == 0, $urandom_range(1) == 1, $urandom_range(9) < 4,
          $urandom_range(9) == 0, $urandom_range(9) < 6, t, $urandom);
    end
    @(negedge clk);
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
